// File: rtl/arm_pkg.sv
// Shared opcodes, control encodings, field ranges and FSM states for the ARM sequencer.
// The state set depends on ARM_IRQ_EN: when it is undefined there is no S_IRQ state.
package arm_pkg;

  localparam logic [7:0] IRQ_VEC = 8'hF0;
  localparam logic [5:0] PC_IDX  = 6'h0C;
  localparam logic [5:0] LNK_IDX = 6'd19;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_IN   = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_MOV  = 4'h3;
  localparam logic [3:0] OP_ALU  = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_CEE  = 4'h6;
  localparam logic [3:0] OP_PUSH = 4'h7;
  localparam logic [3:0] OP_POP  = 4'h8;
  localparam logic [3:0] OP_CALL = 4'h9;
  localparam logic [3:0] OP_RET  = 4'hA;
  localparam logic [3:0] OP_RETI = 4'hB;
  localparam logic [3:0] OP_EI   = 4'hC;
  localparam logic [3:0] OP_DI   = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hE;
  localparam logic [3:0] OP_ILL  = 4'hF;

  localparam logic [1:0] CPC_HOLD = 2'd0;
  localparam logic [1:0] CPC_INC  = 2'd1;
  localparam logic [1:0] CPC_SKIP = 2'd2;

  localparam logic [1:0] SRC_IN  = 2'd0;
  localparam logic [1:0] SRC_LIT = 2'd1;
  localparam logic [1:0] SRC_MUX = 2'd2;
  localparam logic [1:0] SRC_ALU = 2'd3;

  localparam logic [2:0] MSRC_STK = 3'd6;

  localparam int OP_HI  = 23;
  localparam int OP_LO  = 20;
  localparam int DST_HI = 19;
  localparam int DST_LO = 14;
  localparam int SRC_HI = 13;
  localparam int SRC_LO = 11;
  localparam int FN_HI  = 10;
  localparam int FN_LO  = 8;
  localparam int LIT_HI = 7;
  localparam int LIT_LO = 0;

`ifdef ARM_IRQ_EN
  typedef enum logic [2:0] {
    S_FETCH, S_EXEC, S_EXEC2, S_HLT, S_IRQ
  } state_t;
`else
  typedef enum logic [2:0] {
    S_FETCH, S_EXEC, S_EXEC2, S_HLT
  } state_t;
`endif

  typedef struct packed {
    logic [7:0] lit;
    logic [5:0] addr;
    logic [5:0] calu;
    logic [1:0] cpc;
    logic [1:0] csrc;
    logic [2:0] cmsrc;
    logic       wr_en;
    logic       cal;
    logic       ret;
    logic       push;
    logic       pop;
    logic       irq_ack;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/arm_opdec.sv
// Combinational opcode -> control-vector decode for the EXEC cycle.
// RETI shares RET's datapath controls; set_ie marks the interrupt-enable side effects.
module arm_opdec
  import arm_pkg::*;
(
  input  logic [23:0] instr,
  output ctrl_t       ctl,
  output logic        multi,
  output logic        halt,
  output logic        set_ie,
  output logic        clr_ie
);

  logic [3:0] op;
  logic [5:0] dst;
  logic [2:0] src;
  logic [2:0] fn;
  logic [7:0] lit;

  assign op  = instr[OP_HI:OP_LO];
  assign dst = instr[DST_HI:DST_LO];
  assign src = instr[SRC_HI:SRC_LO];
  assign fn  = instr[FN_HI:FN_LO];
  assign lit = instr[LIT_HI:LIT_LO];

  always_comb begin
    ctl      = '0;
    multi    = 1'b0;
    halt     = 1'b0;
    set_ie   = 1'b0;
    clr_ie   = 1'b0;
    ctl.calu = {3'b000, fn};
    ctl.cpc  = CPC_INC;
    unique case (op)
      OP_NOP: ;
      OP_IN: begin
        ctl.addr  = dst;
        ctl.csrc  = SRC_IN;
        ctl.wr_en = 1'b1;
      end
      OP_LD: begin
        ctl.lit   = lit;
        ctl.addr  = dst;
        ctl.csrc  = SRC_LIT;
        ctl.wr_en = 1'b1;
      end
      OP_MOV: begin
        ctl.addr  = dst;
        ctl.csrc  = SRC_MUX;
        ctl.cmsrc = src;
        ctl.wr_en = 1'b1;
      end
      OP_ALU: begin
        ctl.addr  = dst;
        ctl.csrc  = SRC_ALU;
        ctl.wr_en = 1'b1;
      end
      OP_JMP, OP_CALL: begin
        ctl.lit   = lit;
        ctl.addr  = PC_IDX;
        ctl.csrc  = SRC_LIT;
        ctl.wr_en = 1'b1;
        ctl.cpc   = CPC_HOLD;
        ctl.cal   = (op == OP_CALL);
      end
      OP_CEE: begin
        ctl.lit  = lit;
        ctl.csrc = SRC_ALU;
        ctl.cpc  = CPC_SKIP;
      end
      OP_PUSH: begin
        ctl.push  = 1'b1;
        ctl.csrc  = SRC_MUX;
        ctl.cmsrc = src;
        ctl.cpc   = CPC_HOLD;
        multi     = 1'b1;
      end
      OP_POP: begin
        ctl.pop   = 1'b1;
        ctl.csrc  = SRC_MUX;
        ctl.cmsrc = MSRC_STK;
        ctl.addr  = dst;
        ctl.wr_en = 1'b1;
        ctl.cpc   = CPC_HOLD;
        multi     = 1'b1;
      end
      OP_RET, OP_RETI: begin
        ctl.ret  = 1'b1;
        ctl.addr = LNK_IDX;
        ctl.cpc  = CPC_HOLD;
        set_ie   = (op == OP_RETI);
      end
      OP_EI:   set_ie = 1'b1;
      OP_DI:   clr_ie = 1'b1;
      OP_HALT: halt = 1'b1;
      OP_ILL:  ctl.illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/arm_ctrl_seq.sv
// Instruction sequencer: FSM, registered control outputs, PUSH/POP and halt sequencing.
// ARM_IRQ_EN adds edge-triggered external interrupt entry with ie/pending state.
module arm_ctrl_seq
  import arm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] instr,
  input  logic        eint,
  output logic [7:0]  Literal,
  output logic [5:0]  Addr,
  output logic [5:0]  calu,
  output logic [1:0]  cpc,
  output logic [1:0]  csrc,
  output logic [2:0]  cmsrc,
  output logic        wr_en,
  output logic        cal,
  output logic        ret,
  output logic        push,
  output logic        pop,
  output logic        irq_ack,
  output logic        illegal
);

  state_t state, state_n;
  ctrl_t  dec, out_n, out_q;
  logic   multi, halt, set_ie, clr_ie;

  arm_opdec u_dec (
    .instr  (instr),
    .ctl    (dec),
    .multi  (multi),
    .halt   (halt),
    .set_ie (set_ie),
    .clr_ie (clr_ie)
  );

`ifdef ARM_IRQ_EN
  logic ie, ie_n, pend, pend_n, eint_q;
`endif

  always_comb begin
    state_n = state;
    out_n   = '0;
`ifdef ARM_IRQ_EN
    ie_n    = ie;
    pend_n  = pend;
`endif
    unique case (state)
      S_FETCH: state_n = S_EXEC;
      S_EXEC: begin
        out_n = dec;
        if (multi)     state_n = S_EXEC2;
        else if (halt) state_n = S_HLT;
        else           state_n = S_FETCH;
      end
      S_EXEC2: begin
        out_n.cpc = CPC_INC;
        state_n   = S_FETCH;
      end
      S_HLT: state_n = S_HLT;
`ifdef ARM_IRQ_EN
      S_IRQ: begin
        out_n.lit     = IRQ_VEC;
        out_n.addr    = PC_IDX;
        out_n.csrc    = SRC_LIT;
        out_n.cpc     = CPC_HOLD;
        out_n.wr_en   = 1'b1;
        out_n.cal     = 1'b1;
        out_n.irq_ack = 1'b1;
        state_n       = S_FETCH;
      end
`endif
      default: state_n = S_FETCH;
    endcase
`ifdef ARM_IRQ_EN
    if (state == S_EXEC && set_ie) ie_n = 1'b1;
    if (state == S_EXEC && clr_ie) ie_n = 1'b0;
    // The fetched word is dropped; the datapath links the unmodified PC.
    if ((state == S_FETCH || state == S_HLT) && pend && ie) begin
      state_n = S_IRQ;
      pend_n  = 1'b0;
      ie_n    = 1'b0;
    end
    if (eint && !eint_q) pend_n = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_FETCH;
      out_q <= '0;
    end else begin
      state <= state_n;
      out_q <= out_n;
    end
  end

`ifdef ARM_IRQ_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      ie     <= 1'b0;
      pend   <= 1'b0;
      eint_q <= 1'b0;
    end else begin
      ie     <= ie_n;
      pend   <= pend_n;
      eint_q <= eint;
    end
  end

  assign irq_ack = out_q.irq_ack;
`else
  logic unused_irq;
  assign unused_irq = ^{eint, set_ie, clr_ie, out_q.irq_ack};
  assign irq_ack    = 1'b0;
`endif

  assign Literal = out_q.lit;
  assign Addr    = out_q.addr;
  assign calu    = out_q.calu;
  assign cpc     = out_q.cpc;
  assign csrc    = out_q.csrc;
  assign cmsrc   = out_q.cmsrc;
  assign wr_en   = out_q.wr_en;
  assign cal     = out_q.cal;
  assign ret     = out_q.ret;
  assign push    = out_q.push;
  assign pop     = out_q.pop;
  assign illegal = out_q.illegal;

endmodule

// File: tb/tb_arm_ctrl_seq.sv
// Scoreboard bench for arm_ctrl_seq: expected output vectors queued per instruction.
// Interrupt expectations follow ARM_IRQ_EN the same way as the design build.
module tb_arm_ctrl_seq;

`ifdef ARM_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] instr;
  logic        eint;
  logic [7:0]  Literal;
  logic [5:0]  Addr, calu;
  logic [1:0]  cpc, csrc;
  logic [2:0]  cmsrc;
  logic        wr_en, cal, ret, push, pop, irq_ack, illegal;

  arm_ctrl_seq dut (
    .clk     (clk),
    .rst     (rst),
    .instr   (instr),
    .eint    (eint),
    .Literal (Literal),
    .Addr    (Addr),
    .calu    (calu),
    .cpc     (cpc),
    .csrc    (csrc),
    .cmsrc   (cmsrc),
    .wr_en   (wr_en),
    .cal     (cal),
    .ret     (ret),
    .push    (push),
    .pop     (pop),
    .irq_ack (irq_ack),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  // {Literal, Addr, calu, cpc, csrc, cmsrc, wr, cal, ret, push, pop, ack, ill}
  localparam logic [33:0] IDLE = '0;
  localparam logic [33:0] EX2  = {8'h0, 6'h0, 6'h0, 2'd1, 2'd0, 3'd0, 7'b0};
  localparam logic [33:0] IRQV = {8'hF0, 6'h0C, 6'h0, 2'd0, 2'd1, 3'd0,
                                  7'b1100010};

  logic [33:0] sbq[$];
  string       tagq[$];
  int          n_chk = 0;
  int          n_pass = 0;
  bit          m_ie = 1'b0;
  bit          m_pend = 1'b0;

  function automatic logic [23:0] mk(input logic [3:0] op,
                                     input logic [5:0] dst,
                                     input logic [2:0] src,
                                     input logic [2:0] fn,
                                     input logic [7:0] lit);
    return {op, dst, src, fn, lit};
  endfunction

  function automatic logic [33:0] exp_exec(input logic [23:0] w);
    logic [3:0] op;
    logic [5:0] dst;
    logic [7:0] l;
    logic [5:0] a;
    logic [1:0] p, s;
    logic [2:0] m;
    logic [6:0] f;
    op  = w[23:20];
    dst = w[19:14];
    l = '0; a = '0; p = 2'd1; s = 2'd0; m = '0; f = '0;
    case (op)
      4'h1: begin a = dst; f = 7'b1000000; end
      4'h2: begin l = w[7:0]; a = dst; s = 2'd1; f = 7'b1000000; end
      4'h3: begin a = dst; s = 2'd2; m = w[13:11]; f = 7'b1000000; end
      4'h4: begin a = dst; s = 2'd3; f = 7'b1000000; end
      4'h5: begin l = w[7:0]; a = 6'd12; s = 2'd1; p = 2'd0; f = 7'b1000000; end
      4'h6: begin l = w[7:0]; s = 2'd3; p = 2'd2; end
      4'h7: begin s = 2'd2; m = w[13:11]; p = 2'd0; f = 7'b0001000; end
      4'h8: begin a = dst; s = 2'd2; m = 3'd6; p = 2'd0; f = 7'b1000100; end
      4'h9: begin l = w[7:0]; a = 6'd12; s = 2'd1; p = 2'd0; f = 7'b1100000; end
      4'hA, 4'hB: begin a = 6'd19; p = 2'd0; f = 7'b0010000; end
      4'hF: f = 7'b0000001;
      default: ;
    endcase
    return {l, a, {3'b000, w[10:8]}, p, s, m, f};
  endfunction

  task automatic check(input string tag, input logic [33:0] got,
                       input logic [33:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic sb_push(input logic [33:0] v, input string t);
    sbq.push_back(v);
    tagq.push_back(t);
  endtask

  task automatic step();
    logic [33:0] obs;
    @(posedge clk);
    #1;
    obs = {Literal, Addr, calu, cpc, csrc, cmsrc,
           wr_en, cal, ret, push, pop, irq_ack, illegal};
    if (sbq.size() == 0) check("sb_empty", obs, IDLE);
    else check(tagq.pop_front(), obs, sbq.pop_front());
  endtask

  task automatic run();
    int guard = 0;
    while (sbq.size() != 0 && guard < 100) begin
      step();
      guard++;
    end
  endtask

  task automatic issue(input logic [23:0] w, input bit pulse, input string t);
    bit take;
    take  = IRQ && m_pend && m_ie;
    instr = w;
    eint  = pulse;
    if (take) begin
      sb_push(IDLE, {t, "_fetch"});
      sb_push(IRQV, {t, "_irq"});
      m_pend = 1'b0;
      m_ie   = 1'b0;
    end
    sb_push(IDLE, {t, "_fetch"});
    sb_push(exp_exec(w), t);
    if (w[23:20] == 4'h7 || w[23:20] == 4'h8) sb_push(EX2, {t, "_exec2"});
    if (pulse && IRQ) m_pend = 1'b1;
    step();
    eint = 1'b0;
    run();
    if (IRQ && (w[23:20] == 4'hB || w[23:20] == 4'hC)) m_ie = 1'b1;
    if (IRQ && w[23:20] == 4'hD) m_ie = 1'b0;
  endtask

  initial begin
    rst   = 1'b0;
    eint  = 1'b0;
    instr = 24'h20802B;
    sb_push(IDLE, "rst0");
    sb_push(IDLE, "rst1");
    run();
    rst = 1'b1;
    issue(24'h20802B, 1'b0, "ld");
    issue(mk(4'h1, 6'd7, 3'd0, 3'd0, 8'h00), 1'b0, "in");
    issue(mk(4'h3, 6'd5, 3'd3, 3'd0, 8'h00), 1'b0, "mov");
    issue(mk(4'h4, 6'd9, 3'd1, 3'd5, 8'h00), 1'b0, "alu");
    issue(mk(4'h6, 6'd0, 3'd0, 3'd2, 8'h07), 1'b0, "cee");
    issue(mk(4'h5, 6'd0, 3'd0, 3'd0, 8'h33), 1'b0, "jmp");
    issue(mk(4'h0, 6'd0, 3'd0, 3'd4, 8'h00), 1'b0, "nop");
    issue(24'h700000, 1'b0, "push");
    issue(mk(4'h8, 6'd4, 3'd0, 3'd0, 8'h00), 1'b0, "pop");
    issue(24'h9000AA, 1'b0, "call");
    issue(24'hA00000, 1'b0, "ret");
    issue(24'hC00000, 1'b0, "ei");
    issue(24'h000000, 1'b1, "nop_eint");
    issue(mk(4'h2, 6'd1, 3'd0, 3'd0, 8'h55), 1'b0, "ld_irq");
    issue(mk(4'h3, 6'd2, 3'd6, 3'd0, 8'h00), 1'b1, "mov_eint");
    issue(24'h000000, 1'b0, "nop_held");
    issue(24'hB00000, 1'b0, "reti");
    issue(mk(4'h4, 6'd3, 3'd0, 3'd1, 8'h00), 1'b0, "alu_irq");
    issue(24'hB00000, 1'b0, "reti2");
    issue(24'hD00000, 1'b0, "di");
    issue(24'h000000, 1'b1, "nop_di_eint");
    issue(24'h000000, 1'b0, "nop_di");
    issue(24'hC00000, 1'b0, "ei2");
    issue(24'h000000, 1'b0, "nop_irq2");
    issue(24'hF00000, 1'b0, "ill");
    issue(24'h000000, 1'b0, "after_ill");
    instr = 24'h718000;
    sb_push(IDLE, "rpush_fetch");
    sb_push(exp_exec(24'h718000), "rpush");
    run();
    rst = 1'b0;
    sb_push(IDLE, "rpush_abort");
    run();
    rst    = 1'b1;
    m_ie   = 1'b0;
    m_pend = 1'b0;
    issue(24'hC00000, 1'b0, "ei3");
    instr = 24'hE00000;
    sb_push(IDLE, "halt_fetch");
    sb_push(exp_exec(24'hE00000), "halt");
    repeat (20) sb_push(IDLE, "halted");
    run();
    eint = 1'b1;
    sb_push(IDLE, "hlt_eint");
    step();
    eint = 1'b0;
    sb_push(IDLE, "hlt_take");
    sb_push(IRQ ? IRQV : IDLE, "hlt_irq");
    sb_push(IDLE, "hlt_post");
    run();
    rst = 1'b0;
    sb_push(IDLE, "rst_hlt");
    run();
    rst    = 1'b1;
    m_ie   = 1'b0;
    m_pend = 1'b0;
    issue(mk(4'h2, 6'd8, 3'd0, 3'd0, 8'hC3), 1'b0, "ld_end");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
